// File: rtl/tea_seq_core.sv
// tea_seq_core: multi-cycle TEA encrypt/decrypt engine with valid/ready handshakes.
// Define TEA_SEQ_HALF_ROUND_EN to use one F instance and a half-step per RUN cycle.
module tea_seq_core #(
    parameter int          ROUNDS = 32,
    parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_decrypt,
    input  logic [63:0]  in_v,
    input  logic [127:0] in_k,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_v,
    output logic         busy
);
    localparam int CW = $clog2(ROUNDS + 1);
    localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);
    localparam logic [31:0] SUM_DEC = 32'(ROUNDS * DELTA);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;

    logic [31:0]   v0, v1, sum, v0_n, v1_n, sum_n;
    logic [127:0]  k;
    logic          dec, last;
    logic [CW-1:0] cnt;

    function automatic logic [31:0] f(input logic [31:0] x, ka, kb, s);
        return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
    endfunction

`ifdef TEA_SEQ_HALF_ROUND_EN
    logic        phase, hs, sum_up;
    logic [31:0] w, wn;
    // hs selects the v1-update half: encrypt second half, decrypt first half
    always_comb begin
        hs     = dec ^ phase;
        sum_up = !dec && !phase;
        w      = hs ? v1 : v0;
        wn     = dec ? w - f(hs ? v0 : v1, hs ? k[95:64] : k[31:0], hs ? k[127:96] : k[63:32], sum_up ? sum + DELTA : sum)
                     : w + f(hs ? v0 : v1, hs ? k[95:64] : k[31:0], hs ? k[127:96] : k[63:32], sum_up ? sum + DELTA : sum);
        v0_n   = hs ? v0 : wn;
        v1_n   = hs ? wn : v1;
        sum_n  = sum_up ? sum + DELTA : (dec && phase) ? sum - DELTA : sum;
        last   = phase && (cnt == LAST);
    end
`else
    logic [31:0] a, b;
    // a is the word updated first (v0 encrypt, v1 decrypt); b is updated from it
    always_comb begin
        sum_n = dec ? sum - DELTA : sum + DELTA;
        a     = dec ? v1 - f(v0, k[95:64], k[127:96], sum)
                    : v0 + f(v1, k[31:0], k[63:32], sum_n);
        b     = dec ? v0 - f(a, k[31:0], k[63:32], sum)
                    : v1 + f(a, k[95:64], k[127:96], sum_n);
        v0_n  = dec ? b : a;
        v1_n  = dec ? a : b;
        last  = cnt == LAST;
    end
`endif

    always_comb begin
        state_n   = state;
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        busy      = state != IDLE;
        case (state)
            IDLE:    state_n = in_valid ? RUN : IDLE;
            RUN:     state_n = last ? DONE : RUN;
            DONE:    state_n = out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            v0    <= '0;
            v1    <= '0;
            sum   <= '0;
            cnt   <= '0;
            k     <= '0;
            dec   <= 1'b0;
            out_v <= '0;
`ifdef TEA_SEQ_HALF_ROUND_EN
            phase <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (state == IDLE && in_valid) begin
                v0  <= in_v[63:32];
                v1  <= in_v[31:0];
                k   <= in_k;
                dec <= in_decrypt;
                sum <= in_decrypt ? SUM_DEC : 32'h0;
                cnt <= '0;
`ifdef TEA_SEQ_HALF_ROUND_EN
                phase <= 1'b0;
`endif
            end else if (state == RUN) begin
                v0  <= v0_n;
                v1  <= v1_n;
                sum <= sum_n;
`ifdef TEA_SEQ_HALF_ROUND_EN
                phase <= ~phase;
                if (phase)
                    cnt <= cnt + 1'b1;
`else
                cnt <= cnt + 1'b1;
`endif
                if (last)
                    out_v <= {v0_n, v1_n};
            end
        end
    end
endmodule

// File: tb/tb_tea_seq_core.sv
// tb_tea_seq_core: directed and model-checked tests for tea_seq_core (ROUNDS=32 and ROUNDS=1 instances).
module tb_tea_seq_core;
    localparam logic [31:0] D = 32'h9E3779B9;
    localparam logic [63:0] ENC0 = 64'h41EA3A0A_94BAA940;
`ifdef TEA_SEQ_HALF_ROUND_EN
    localparam int LAT = 64, LAT1 = 2;
`else
    localparam int LAT = 32, LAT1 = 1;
`endif

    logic         clk = 0, rst_n = 0;
    logic         in_valid = 0, in_decrypt = 0, out_ready = 1;
    logic [63:0]  in_v = '0;
    logic [127:0] in_k = '0;
    logic         in_ready, out_valid, busy;
    logic [63:0]  out_v;

    logic         b_valid = 0, b_decrypt = 0, b_oready = 1;
    logic [63:0]  b_v = '0;
    logic [127:0] b_k = '0;
    logic         b_iready, b_ovalid, b_busy;
    logic [63:0]  b_out;

    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    tea_seq_core u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_decrypt(in_decrypt), .in_v(in_v), .in_k(in_k), .out_valid(out_valid),
        .out_ready(out_ready), .out_v(out_v), .busy(busy)
    );

    tea_seq_core #(.ROUNDS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_iready),
        .in_decrypt(b_decrypt), .in_v(b_v), .in_k(b_k), .out_valid(b_ovalid),
        .out_ready(b_oready), .out_v(b_out), .busy(b_busy)
    );

    function automatic logic [63:0] tea(input logic dec, input logic [63:0] v, input logic [127:0] k, input int n);
        logic [31:0] y = v[63:32], z = v[31:0], s;
        logic [31:0] k0 = k[31:0], k1 = k[63:32], k2 = k[95:64], k3 = k[127:96];
        s = dec ? 32'(n * D) : 32'h0;
        for (int i = 0; i < n; i++) begin
            if (!dec) begin
                s += D;
                y += ((z << 4) + k0) ^ (z + s) ^ ((z >> 5) + k1);
                z += ((y << 4) + k2) ^ (y + s) ^ ((y >> 5) + k3);
            end else begin
                z -= ((y << 4) + k2) ^ (y + s) ^ ((y >> 5) + k3);
                y -= ((z << 4) + k0) ^ (z + s) ^ ((z >> 5) + k1);
                s -= D;
            end
        end
        return {y, z};
    endfunction

    task automatic xfer(input logic dec, input logic [63:0] v, input logic [127:0] k,
                        output logic [63:0] r, output int lat);
        in_valid = 1; in_decrypt = dec; in_v = v; in_k = k;
        @(posedge clk); #1;
        in_decrypt = ~dec; in_k = ~k; in_v = ~v;
        lat = 0;
        do begin
            in_valid = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 300);
        in_valid = 0;
        r = out_v;
        @(posedge clk); #1;
    endtask

    task automatic xfer1(input logic dec, input logic [63:0] v, input logic [127:0] k,
                         output logic [63:0] r, output int lat);
        b_valid = 1; b_decrypt = dec; b_v = v; b_k = k;
        @(posedge clk); #1;
        b_valid = 0; b_decrypt = ~dec; b_k = ~k;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!b_ovalid && lat < 20);
        r = b_out;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_v !== 64'h0) begin
            fails++;
            $display("FAIL reset: in_ready=%b out_valid=%b busy=%b out_v=%h required 1 0 0 0", in_ready, out_valid, busy, out_v);
        end
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_known;
        logic [63:0] r;
        int lat;
        xfer(0, 64'h0, 128'h0, r, lat);
        tests++;
        if (r !== ENC0) begin fails++; $display("FAIL enc_zero: got %h required %h", r, ENC0); end
        tests++;
        if (lat !== LAT) begin fails++; $display("FAIL enc_latency: got %0d required %0d", lat, LAT); end
        xfer(1, ENC0, 128'h0, r, lat);
        tests++;
        if (r !== 64'h0) begin fails++; $display("FAIL dec_known: got %h required 0", r); end
        tests++;
        if (lat !== LAT) begin fails++; $display("FAIL dec_latency: got %0d required %0d", lat, LAT); end
    endtask

    task automatic test_random;
        logic [63:0] v, r, r2;
        logic [127:0] k;
        int lat;
        for (int i = 0; i < 100; i++) begin
            v = {$urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            xfer(0, v, k, r, lat);
            tests++;
            if (r !== tea(0, v, k, 32)) begin fails++; $display("FAIL rand_enc %0d: got %h required %h", i, r, tea(0, v, k, 32)); end
            xfer(1, r, k, r2, lat);
            tests++;
            if (r2 !== v) begin fails++; $display("FAIL rand_enc_trip %0d: got %h required %h", i, r2, v); end
            xfer(1, v, k, r, lat);
            tests++;
            if (r !== tea(1, v, k, 32)) begin fails++; $display("FAIL rand_dec %0d: got %h required %h", i, r, tea(1, v, k, 32)); end
            xfer(0, r, k, r2, lat);
            tests++;
            if (r2 !== v) begin fails++; $display("FAIL rand_dec_trip %0d: got %h required %h", i, r2, v); end
        end
    endtask

    task automatic test_hold;
        logic [63:0] v = 64'h01234567_89ABCDEF, r;
        logic [127:0] k = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        int lat = 0;
        out_ready = 0;
        in_valid = 1; in_decrypt = 0; in_v = v; in_k = k;
        @(posedge clk); #1;
        in_valid = 0;
        while (!out_valid && lat < 300) begin @(posedge clk); #1; lat++; end
        r = out_v;
        tests++;
        if (r !== tea(0, v, k, 32)) begin fails++; $display("FAIL hold_result: got %h required %h", r, tea(0, v, k, 32)); end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom); in_v = {$urandom, $urandom}; in_decrypt = 1'($urandom);
            @(posedge clk); #1;
            tests++;
            if (out_v !== r || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL hold_cycle %0d: out_v=%h in_ready=%b out_valid=%b required %h 0 1", i, out_v, in_ready, out_valid, r);
            end
        end
        in_valid = 0; out_ready = 1;
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL hold_release: out_valid=%b in_ready=%b busy=%b required 0 1 0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset_mid;
        logic [63:0] r;
        int lat;
        in_valid = 1; in_decrypt = 0; in_v = 64'hFFFF0000_12345678; in_k = '1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (15) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_v !== 64'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid: out_valid=%b out_v=%h busy=%b in_ready=%b required 0 0 0 1", out_valid, out_v, busy, in_ready);
        end
        #2 rst_n = 1;
        @(posedge clk); #1;
        xfer(0, 64'h0, 128'h0, r, lat);
        tests++;
        if (r !== ENC0 || lat !== LAT) begin
            fails++;
            $display("FAIL reset_mid_rerun: got %h lat %0d required %h lat %0d", r, lat, ENC0, LAT);
        end
    endtask

    task automatic test_back_to_back;
        int first = -1, second = -1;
        logic prev = 0;
        in_valid = 1; in_decrypt = 0; in_v = '0; in_k = '0;
        for (int c = 1; c < 3 * LAT + 10 && second < 0; c++) begin
            @(posedge clk); #1;
            if (busy && !prev) begin
                if (first < 0) first = c; else second = c;
            end
            prev = busy;
        end
        in_valid = 0;
        tests++;
        if (second - first !== LAT + 2) begin
            fails++;
            $display("FAIL back_to_back: period %0d required %0d", second - first, LAT + 2);
        end
        repeat (LAT + 4) @(posedge clk);
        #1;
    endtask

    task automatic test_rounds1;
        logic [63:0] v, r, r2;
        logic [127:0] k;
        int lat;
        for (int i = 0; i < 20; i++) begin
            v = {$urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            xfer1(0, v, k, r, lat);
            tests++;
            if (r !== tea(0, v, k, 1) || lat !== LAT1) begin
                fails++;
                $display("FAIL r1_enc %0d: got %h lat %0d required %h lat %0d", i, r, lat, tea(0, v, k, 1), LAT1);
            end
            xfer1(1, r, k, r2, lat);
            tests++;
            if (r2 !== v || lat !== LAT1) begin
                fails++;
                $display("FAIL r1_trip %0d: got %h lat %0d required %h lat %0d", i, r2, lat, v, LAT1);
            end
        end
    endtask

    initial begin
        test_reset;
        test_known;
        test_random;
        test_hold;
        test_reset_mid;
        test_back_to_back;
        test_rounds1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
